// File: rtl/banked_cache_arbiter_pkg.sv
// Shared widths and the central request-queue entry layout for the banked cache arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif

package banked_cache_arbiter_pkg;

    localparam int DATA_W = `DATA_WIDTH;
    localparam int ADDR_W = `CACHE_BANK_ADDRESS_WIDTH;
    localparam int NET_W  = `NETWORK_ADDRESS_WIDTH;
    // source port index (N,S,E,W)
    localparam int SRC_W  = 2;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [NET_W-1:0]  requester;
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
    } entry_t;

endpackage

// File: rtl/arb_request_queue.sv
// Central request FIFO: up to PUSH_N pushes and POP_N pops per cycle, head entries exposed.
module arb_request_queue
    import banked_cache_arbiter_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PUSH_N = 4,
    parameter int POP_N  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(PUSH_N+1)-1:0] push_num,
    input  entry_t                      push_entry [PUSH_N],
    input  logic [$clog2(POP_N+1)-1:0]  pop_num,
    output entry_t                      head [POP_N],
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    entry_t           mem [DEPTH];

    // entry storage; contents are meaningless until counted, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_N; i++) begin
            if (i < int'(push_num)) begin
                mem[wptr + PTR_W'(i)] <= push_entry[i];
            end
        end
    end

    // pointers wrap naturally; occupancy tracks pushes minus pops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PTR_W'(push_num);
            rptr  <= rptr + PTR_W'(pop_num);
            count <= count + CNT_W'(push_num) - CNT_W'(pop_num);
        end
    end

    // oldest POP_N entries, slot k feeds bank port k
    always_comb begin
        for (int k = 0; k < POP_N; k++) begin
            head[k] = mem[rptr + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/banked_cache_arbiter.sv
// Round-robin multi-port request arbiter feeding registered cache bank ports, with response routing.
module banked_cache_arbiter
    import banked_cache_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int NUM_BANK_PORTS = 2,
    parameter int QUEUE_DEPTH    = 8,
    parameter int DATA_WIDTH     = DATA_W,
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int NET_WIDTH      = NET_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                reqValid,
    output logic [NUM_PORTS-1:0]                reqReady,
    input  logic [NUM_PORTS-1:0]                reqWrite,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     reqAddr,
    input  logic [NUM_PORTS*NET_WIDTH-1:0]      reqRequester,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     reqData,
    output logic [NUM_PORTS-1:0]                respValid,
    output logic [NUM_PORTS*NET_WIDTH-1:0]      respRequester,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]     respData,
    output logic [NUM_BANK_PORTS*ADDR_WIDTH-1:0] bankAddr,
    output logic [NUM_BANK_PORTS*DATA_WIDTH-1:0] bankDataIn,
    output logic [NUM_BANK_PORTS-1:0]           bankWrite_n,
    input  logic [NUM_BANK_PORTS*DATA_WIDTH-1:0] bankDataOut,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]    queueCount
);

    localparam int CNT_W   = $clog2(QUEUE_DEPTH+1);
    localparam int P_CNT_W = $clog2(NUM_PORTS+1);
    localparam int B_CNT_W = $clog2(NUM_BANK_PORTS+1);
    localparam int RR_W    = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]       grant;
    entry_t                     push_entry [NUM_PORTS];
    logic [P_CNT_W-1:0]         push_num;
    logic [B_CNT_W-1:0]         pop_num;
    entry_t                     head [NUM_BANK_PORTS];
    logic [CNT_W-1:0]           queue_count;
    logic [RR_W-1:0]            rr_ptr;
    logic [RR_W-1:0]            rr_next;
    logic [NUM_BANK_PORTS-1:0]  issue;
    logic [NUM_BANK_PORTS-1:0]  rd_valid;
    logic [SRC_W-1:0]           rd_src [NUM_BANK_PORTS];
    logic [NET_WIDTH-1:0]       rd_req [NUM_BANK_PORTS];
    logic [NUM_PORTS-1:0]       resp_hit;
    logic [NUM_PORTS*DATA_WIDTH-1:0] resp_data_sel;
    logic [NUM_PORTS*NET_WIDTH-1:0]  resp_req_sel;

    arb_request_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .PUSH_N (NUM_PORTS),
        .POP_N  (NUM_BANK_PORTS)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push_num   (push_num),
        .push_entry (push_entry),
        .pop_num    (pop_num),
        .head       (head),
        .count      (queue_count)
    );

    assign queueCount = queue_count;
    // space freed by this cycle's pops is only visible next cycle, so grants use current occupancy
    assign reqReady   = grant & {NUM_PORTS{reset}};

    // round-robin grant from rr_ptr, packing accepted requests into push slots in grant order
    always_comb begin
        int n;
        int p;
        int free;
        grant   = '0;
        rr_next = rr_ptr;
        n       = 0;
        free    = QUEUE_DEPTH - int'(queue_count);
        for (int i = 0; i < NUM_PORTS; i++) begin
            push_entry[i] = '0;
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = (int'(rr_ptr) + k) % NUM_PORTS;
            if (reqValid[p] && n < free) begin
                grant[p] = 1'b1;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (i == n) begin
                        push_entry[i].write     = reqWrite[p];
                        push_entry[i].addr      = reqAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
                        push_entry[i].requester = reqRequester[p*NET_WIDTH +: NET_WIDTH];
                        push_entry[i].data      = reqData[p*DATA_WIDTH +: DATA_WIDTH];
                        push_entry[i].src       = SRC_W'(p);
                    end
                end
                n++;
                rr_next = RR_W'((p + 1) % NUM_PORTS);
            end
        end
        push_num = P_CNT_W'(n);
    end

    // rr_ptr moves one past the last accepted port, holds when nothing is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    // issue an in-order prefix of the head, stopping at an address hazard or a second read per source
    always_comb begin
        logic stop;
        logic clash;
        issue   = '0;
        stop    = 1'b0;
        pop_num = '0;
        for (int k = 0; k < NUM_BANK_PORTS; k++) begin
            clash = 1'b0;
            for (int j = 0; j < NUM_BANK_PORTS; j++) begin
                if (j < k) begin
                    if (head[j].addr == head[k].addr && (head[j].write || head[k].write)) clash = 1'b1;
                    if (!head[j].write && !head[k].write && head[j].src == head[k].src) clash = 1'b1;
                end
            end
            if (stop || k >= int'(queue_count) || clash) begin
                stop = 1'b1;
            end else begin
                issue[k] = 1'b1;
                pop_num  = B_CNT_W'(k + 1);
            end
        end
    end

    // bank port registers and in-flight read tags; idle ports hold address/data with the strobe off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bankAddr    <= '0;
            bankDataIn  <= '0;
            bankWrite_n <= '1;
            rd_valid    <= '0;
            for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                rd_src[k] <= '0;
                rd_req[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                if (issue[k]) begin
                    bankAddr[k*ADDR_WIDTH +: ADDR_WIDTH]   <= head[k].addr;
                    bankDataIn[k*DATA_WIDTH +: DATA_WIDTH] <= head[k].data;
                    bankWrite_n[k] <= ~head[k].write;
                    rd_valid[k]    <= ~head[k].write;
                    rd_src[k]      <= head[k].src;
                    rd_req[k]      <= head[k].requester;
                end else begin
                    bankWrite_n[k] <= 1'b1;
                    rd_valid[k]    <= 1'b0;
                end
            end
        end
    end

    // route each returning read to its source port; at most one read per source is in flight
    always_comb begin
        resp_hit      = '0;
        resp_data_sel = '0;
        resp_req_sel  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int k = 0; k < NUM_BANK_PORTS; k++) begin
                if (rd_valid[k] && int'(rd_src[k]) == p) begin
                    resp_hit[p] = 1'b1;
                    resp_data_sel[p*DATA_WIDTH +: DATA_WIDTH] = bankDataOut[k*DATA_WIDTH +: DATA_WIDTH];
                    resp_req_sel[p*NET_WIDTH +: NET_WIDTH]    = rd_req[k];
                end
            end
        end
    end

    // registered response: one-cycle valid pulse, payload held between responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            respValid     <= '0;
            respData      <= '0;
            respRequester <= '0;
        end else begin
            respValid <= resp_hit;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (resp_hit[p]) begin
                    respData[p*DATA_WIDTH +: DATA_WIDTH]     <= resp_data_sel[p*DATA_WIDTH +: DATA_WIDTH];
                    respRequester[p*NET_WIDTH +: NET_WIDTH]  <= resp_req_sel[p*NET_WIDTH +: NET_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_banked_cache_arbiter.sv
// Randomized and directed bench for banked_cache_arbiter against a queue-based reference model.
module tb_banked_cache_arbiter;

    localparam int P  = 4;
    localparam int B  = 2;
    localparam int D  = 8;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [P-1:0]    reqValid, reqReady, reqWrite, respValid;
    logic [P*AW-1:0] reqAddr;
    logic [P*NW-1:0] reqRequester, respRequester;
    logic [P*DW-1:0] reqData, respData;
    logic [B*AW-1:0] bankAddr;
    logic [B*DW-1:0] bankDataIn, bankDataOut;
    logic [B-1:0]    bankWrite_n;
    logic [3:0]      queueCount;

    always #5 clk = ~clk;

    banked_cache_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .reqWrite      (reqWrite),
        .reqAddr       (reqAddr),
        .reqRequester  (reqRequester),
        .reqData       (reqData),
        .respValid     (respValid),
        .respRequester (respRequester),
        .respData      (respData),
        .bankAddr      (bankAddr),
        .bankDataIn    (bankDataIn),
        .bankWrite_n   (bankWrite_n),
        .bankDataOut   (bankDataOut),
        .queueCount    (queueCount)
    );

    // cache bank: read data follows the registered address, writes land on the next edge
    logic [DW-1:0] bmem [256];
    always_comb begin
        for (int k = 0; k < B; k++) bankDataOut[k*DW +: DW] = bmem[bankAddr[k*AW +: AW]];
    end
    always @(posedge clk) begin
        for (int k = 0; k < B; k++)
            if (!bankWrite_n[k]) bmem[bankAddr[k*AW +: AW]] <= bankDataIn[k*DW +: DW];
    end

    typedef struct { bit wr; int addr; int rq; int dat; int src; } req_t;

    req_t       mq[$];
    int         rr;
    int         mmem [256];
    logic [3:0] exp_grant;
    logic [3:0] pend_rv;
    int         pend_rd [4];
    int         pend_rq [4];
    int         ebaddr [2];
    int         ebdat [2];
    logic [1:0] ewn;
    int         n_chk = 0;
    int         n_fail = 0;

    logic [3:0] vld, wr;
    int         a [4];
    int         r [4];
    int         d [4];

    function automatic int init_val(int i);
        return (i * 37 + 5) & 16'hffff;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply();
        reqValid = vld;
        reqWrite = wr;
        for (int p = 0; p < P; p++) begin
            reqAddr[p*AW +: AW]      = AW'(a[p]);
            reqRequester[p*NW +: NW] = NW'(r[p]);
            reqData[p*DW +: DW]      = DW'(d[p]);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rr = 0;
        pend_rv = '0;
        ewn = 2'b11;
        ebaddr[0] = 0;
        ebaddr[1] = 0;
        for (int i = 0; i < 256; i++) mmem[i] = int'(bmem[i]);
    endtask

    // acceptance: round-robin from rr, limited by the free entries at the start of the cycle
    task automatic model_grant();
        int n, free, p;
        free = D - mq.size();
        n = 0;
        exp_grant = '0;
        for (int k = 0; k < P; k++) begin
            p = (rr + k) % P;
            if (vld[p] && n < free) begin
                exp_grant[p] = 1'b1;
                n++;
            end
        end
    endtask

    task automatic model_edge();
        int nb, last, p;
        bit stop, clash, any;
        req_t e;
        logic [3:0] new_rv;
        int new_rd [4];
        int new_rq [4];
        nb = 0;
        stop = 0;
        for (int k = 0; k < B; k++) begin
            if (!stop && k < mq.size()) begin
                clash = 0;
                for (int j = 0; j < k; j++) begin
                    if (mq[j].addr == mq[k].addr && (mq[j].wr || mq[k].wr)) clash = 1;
                    if (!mq[j].wr && !mq[k].wr && mq[j].src == mq[k].src) clash = 1;
                end
                if (clash) stop = 1; else nb = k + 1;
            end else stop = 1;
        end
        new_rv = '0;
        for (int k = 0; k < 4; k++) begin
            new_rd[k] = 0;
            new_rq[k] = 0;
        end
        for (int k = 0; k < B; k++) begin
            if (k < nb) begin
                e = mq[k];
                ebaddr[k] = e.addr;
                ewn[k] = !e.wr;
                if (e.wr) begin
                    mmem[e.addr] = e.dat;
                    ebdat[k] = e.dat;
                end else begin
                    new_rv[e.src] = 1'b1;
                    new_rd[e.src] = mmem[e.addr];
                    new_rq[e.src] = e.rq;
                end
            end else begin
                ewn[k] = 1'b1;
            end
        end
        check("respValid", respValid, pend_rv);
        for (int q = 0; q < P; q++) begin
            if (pend_rv[q]) begin
                check("respData", respData[q*DW +: DW], 64'(pend_rd[q]));
                check("respRequester", respRequester[q*NW +: NW], 64'(pend_rq[q]));
            end
        end
        pend_rv = new_rv;
        pend_rd = new_rd;
        pend_rq = new_rq;
        for (int k = 0; k < nb; k++) e = mq.pop_front();
        any = 0;
        last = 0;
        for (int k = 0; k < P; k++) begin
            p = (rr + k) % P;
            if (exp_grant[p]) begin
                mq.push_back('{wr: wr[p], addr: a[p], rq: r[p], dat: d[p], src: p});
                last = p;
                any = 1;
            end
        end
        if (any) rr = (last + 1) % P;
        check("queueCount", queueCount, 64'(mq.size()));
        for (int k = 0; k < B; k++) begin
            check("bankWrite_n", bankWrite_n[k], ewn[k]);
            check("bankAddr", bankAddr[k*AW +: AW], 64'(ebaddr[k]));
            if (!ewn[k]) check("bankDataIn", bankDataIn[k*DW +: DW], 64'(ebdat[k]));
        end
    endtask

    task automatic cycle();
        #1;
        model_grant();
        check("reqReady", reqReady, exp_grant);
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic idle_inputs();
        vld = '0;
        wr = '0;
        for (int p = 0; p < P; p++) begin
            a[p] = 0;
            r[p] = 0;
            d[p] = 0;
        end
    endtask

    task automatic rand_inputs(int pct);
        for (int p = 0; p < P; p++) begin
            vld[p] = ($urandom_range(0, 99) < pct);
            wr[p]  = $urandom_range(0, 1);
            a[p]   = $urandom_range(0, 7);
            r[p]   = $urandom_range(0, 15);
            d[p]   = $urandom_range(0, 65535);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = DW'(init_val(i));
        idle_inputs();
        vld = 4'b1111;
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_reqReady", reqReady, 0);
        check("rst_queueCount", queueCount, 0);
        check("rst_bankWrite_n", bankWrite_n, 2'b11);
        check("rst_respValid", respValid, 0);
        idle_inputs();
        apply();
        @(negedge clk);
        reset = 1'b1;

        // four simultaneous writes from rr_ptr = 0
        vld = 4'b1111;
        wr  = 4'b1111;
        for (int p = 0; p < P; p++) begin
            a[p] = 'h20 + p;
            d[p] = 'h1000 + p;
        end
        apply();
        cycle();
        idle_inputs();
        apply();
        cycle();
        check("wr4_first_addr0", bankAddr[AW-1:0], 'h20);
        check("wr4_first_addr1", bankAddr[2*AW-1:AW], 'h21);
        check("wr4_first_wn", bankWrite_n, 2'b00);
        cycle();
        check("wr4_second_addr0", bankAddr[AW-1:0], 'h22);
        check("wr4_second_wn", bankWrite_n, 2'b00);

        // single read from port 2 at address 0x05
        vld = 4'b0100;
        a[2] = 'h05;
        r[2] = 9;
        apply();
        cycle();
        idle_inputs();
        apply();
        cycle();
        check("single_bank_addr", bankAddr[AW-1:0], 'h05);
        check("single_respValid_early", respValid, 0);
        cycle();
        check("single_respValid", respValid, 4'b0100);
        check("single_respData", respData[2*DW +: DW], 64'(init_val(5)));

        // same-address write then read in one cycle
        vld = 4'b0011;
        wr  = 4'b0001;
        a[0] = 'h10;
        a[1] = 'h10;
        d[0] = 'hbeef;
        r[1] = 3;
        apply();
        cycle();
        idle_inputs();
        apply();
        cycle();
        check("hazard_write_alone", bankWrite_n, 2'b10);
        cycle();
        check("hazard_read_addr", bankAddr[AW-1:0], 'h10);
        cycle();
        check("hazard_resp", respValid, 4'b0010);
        check("hazard_resp_data", respData[DW +: DW], 'hbeef);

        // randomized traffic: heavy load fills the queue, light load drains it
        for (int c = 0; c < 600; c++) begin
            rand_inputs((c % 100) < 70 ? 95 : 20);
            apply();
            cycle();
        end

        // reset in the middle of traffic
        for (int c = 0; c < 6; c++) begin
            rand_inputs(100);
            apply();
            cycle();
        end
        vld = 4'b1111;
        apply();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_queueCount", queueCount, 0);
        check("midrst_reqReady", reqReady, 0);
        check("midrst_respValid", respValid, 0);
        check("midrst_bankWrite_n", bankWrite_n, 2'b11);
        check("midrst_bankAddr", bankAddr, 0);
        check("midrst_respData", respData, 0);
        model_reset();
        idle_inputs();
        apply();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) cycle();

        for (int c = 0; c < 200; c++) begin
            rand_inputs(80);
            apply();
            cycle();
        end
        idle_inputs();
        apply();
        for (int c = 0; c < 20; c++) cycle();
        check("drained", queueCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
